// File: rtl/serial_accumulator.sv
// Bit-serial accumulator store: N = MC_BITS*ACC_CYCLES bit circulating register with LOAD/CLEAR/SHR/SHL passes.
// Optional sticky overflow flag and port enabled by defining SERIAL_ACC_OVF_EN.
module serial_accumulator #(
  parameter  int MC_BITS    = 36,
  parameter  int ACC_CYCLES = 2,
  localparam int N          = MC_BITS * ACC_CYCLES,
  localparam int PW         = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adder_sum,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  output logic          busy,
  input  logic          c10,
  input  logic          c25,
  input  logic          jump_uc,
  input  logic          dv,
  output logic          acc,
  output logic          acc1,
  output logic          sign,
  output logic [PW-1:0] pos,
  output logic          dv_d
`ifdef SERIAL_ACC_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] MCB  = PW'(MC_BITS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_SHR, S_SHL} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  store;
  logic          prev_bit;   // old value of position pos-1, needed because SHL overwrites it first
  logic          new_bit;
  logic [PW-1:0] pos_p1;
  logic          at_last;

  assign at_last   = (pos == LAST);
  assign pos_p1    = at_last ? LAST : pos + 1'b1;
  assign acc       = store[pos];
  assign acc1      = (pos < MCB) ? acc : 1'b0;
  assign busy      = (state != S_IDLE);
  assign cmd_ready = (state == S_IDLE) && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    new_bit   = store[pos];
    case (state)
      S_IDLE: begin
        if (cmd_valid && at_last) begin
          case (cmd)
            2'd0:    state_nxt = S_LOAD;
            2'd1:    state_nxt = S_CLEAR;
            2'd2:    state_nxt = S_SHR;
            default: state_nxt = S_SHL;
          endcase
        end
      end
      S_LOAD:  new_bit = adder_sum;
      S_CLEAR: new_bit = 1'b0;
      S_SHR:   new_bit = store[pos_p1];   // at N-1 pos_p1 stays N-1: sign propagates
      S_SHL:   new_bit = (pos == '0) ? 1'b0 : prev_bit;
      default: new_bit = store[pos];
    endcase
    if (state != S_IDLE && at_last) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store    <= '0;
      pos      <= LAST;
      prev_bit <= 1'b0;
      sign     <= 1'b0;
      dv_d     <= 1'b0;
    end else begin
      store[pos] <= new_bit;
      prev_bit   <= store[pos];
      pos        <= at_last ? '0 : pos + 1'b1;
      if (at_last) sign <= new_bit;
      // Uses the pre-update sign when the sign bit is written on the same edge.
      dv_d <= dv & (jump_uc | (c25 & ~sign) | (c10 & sign));
    end
  end

`ifdef SERIAL_ACC_OVF_EN
  // LOAD overflow: result sign differs from both the stored operand sign bit and the latched sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (at_last) begin
      case (state)
        S_SHL:   if (new_bit != store[N-1]) ovf <= 1'b1;
        S_LOAD:  if ((new_bit != store[N-1]) && (new_bit != sign)) ovf <= 1'b1;
        S_CLEAR: ovf <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_serial_accumulator.sv
// Self-checking bench for serial_accumulator: word-level store model compared every cycle, plus literal pins.
module tb_serial_accumulator;
  localparam int MC = 36, AC = 2, N = MC * AC, PW = $clog2(N), LAST = N - 1;

  logic clk = 1'b0, rst = 1'b1, adder_sum = 1'b0, cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic c10 = 1'b0, c25 = 1'b0, jump_uc = 1'b0, dv = 1'b0;
  logic cmd_ready, busy, acc, acc1, sign, dv_d;
  logic [PW-1:0] pos;
`ifdef SERIAL_ACC_OVF_EN
  logic ovf;
`endif

  serial_accumulator #(.MC_BITS(MC), .ACC_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .adder_sum(adder_sum), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .busy(busy), .c10(c10), .c25(c25), .jump_uc(jump_uc), .dv(dv),
    .acc(acc), .acc1(acc1), .sign(sign), .pos(pos), .dv_d(dv_d)
`ifdef SERIAL_ACC_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0, rnd_en = 1'b0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: an operation commits its whole result when its pass ends.
  logic [N-1:0] mval, mload;
  int mop, mpos;
  logic mdv_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mval = '0; mload = '0; mop = -1; mpos = LAST; mdv_d = 1'b0;
    end else begin
      mdv_d = dv & (jump_uc | (c25 & ~mval[N-1]) | (c10 & mval[N-1]));
      if (mop < 0) begin
        if (cmd_valid && mpos == LAST) begin mop = int'(cmd); mload = '0; end
      end else begin
        if (mop == 0) mload[mpos] = adder_sum;
        if (mpos == LAST) begin
          case (mop)
            0:       mval = mload;
            1:       mval = '0;
            2:       mval = {mval[N-1], mval[N-1:1]};
            default: mval = {mval[N-2:0], 1'b0};
          endcase
          mop = -1;
        end
      end
      mpos = (mpos == LAST) ? 0 : mpos + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("pos", N'(pos), N'(mpos));
      chk("busy", N'(busy), N'(mop >= 0));
      chk("cmd_ready", N'(cmd_ready), N'(mop < 0 && mpos == LAST));
      chk("acc", N'(acc), N'(mval[mpos]));
      chk("acc1", N'(acc1), N'((mpos < MC) ? mval[mpos] : 1'b0));
      chk("sign", N'(sign), N'(mval[N-1]));
      chk("dv_d", N'(dv_d), N'(mdv_d));
    end
  end

  int busy_run = 0;
  always @(negedge clk) begin
    if (rst) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run != 0) begin
      chk("busy_len", N'(busy_run), N'(N));
      busy_run = 0;
    end
  end

  // Raises cmd_valid immediately (usually off the acceptance slot) and holds it until taken.
  task automatic issue(input logic [1:0] c, input logic [N-1:0] v);
    int w = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd = c;
    @(negedge clk);
    while (!cmd_ready && w < 3 * N) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      chk("issue_timeout", 1, 0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      adder_sum = v[i];
      if (rnd_en) {dv, c10, c25, jump_uc} = 4'($urandom);
      @(posedge clk); #1;
    end
    adder_sum = 1'($urandom);
  endtask

  task automatic read_store(output logic [N-1:0] v);
    v = '0;
    for (int i = 0; i < N; i++) begin @(negedge clk); v[pos] = acc; end
  endtask

  task automatic dv_step(input logic d, input logic a, input logic b, input logic u, input logic exp, input string nm);
    @(negedge clk);
    dv = d; c10 = a; c25 = b; jump_uc = u;
    @(posedge clk); @(negedge clk);
    chk(nm, N'(dv_d), N'(exp));
  endtask

  logic [N-1:0] r, rv;
  int w;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pos", N'(pos), N'(LAST));
    chk("rst_ready", N'(cmd_ready), 1);
    chk("rst_busy", N'(busy), 0);
    chk("rst_acc", N'(acc), 0);
    @(posedge clk); #1;
    // First edge after reset release accepts a command.
    rst = 1'b0; cmd_valid = 1'b1; cmd = 2'd1; chk_en = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("first_accept", N'(busy), 1);
    repeat (N) @(posedge clk);

    issue(2'd0, 72'h5);
    read_store(r);
    chk("load5", r, 72'h5);
    chk("load5_sign", N'(sign), 0);

    issue(2'd0, 72'h80_0000_0000_0000_0003);
    issue(2'd2, '0);
    read_store(r);
    chk("shr", r, 72'hC0_0000_0000_0000_0001);
    chk("shr_sign", N'(sign), 1);

    dv_step(1, 1, 0, 0, 1, "dv_c10_neg");
    dv_step(1, 0, 1, 0, 0, "dv_c25_neg");
    dv_step(1, 0, 0, 1, 1, "dv_uc_neg");
    dv_step(0, 1, 1, 1, 0, "dv_off");

    issue(2'd3, '0);
    read_store(r);
    chk("shl", r, 72'h80_0000_0000_0000_0002);

    issue(2'd1, '0);
    read_store(r);
    chk("clear", r, '0);
    dv_step(1, 0, 1, 0, 1, "dv_c25_pos");
    dv_step(1, 1, 0, 0, 0, "dv_c10_pos");
    dv_step(1, 0, 0, 1, 1, "dv_uc_pos");
    dv_step(0, 0, 0, 0, 0, "dv_idle");

`ifdef SERIAL_ACC_OVF_EN
    issue(2'd0, 72'h40_0000_0000_0000_0000);
    @(negedge clk); chk("ovf_load", N'(ovf), 0);
    issue(2'd3, '0);
    @(negedge clk); chk("ovf_shl", N'(ovf), 1);
    issue(2'd2, '0);
    @(negedge clk); chk("ovf_sticky", N'(ovf), 1);
    issue(2'd1, '0);
    @(negedge clk); chk("ovf_clear", N'(ovf), 0);
`endif

    // Abort a LOAD of all ones at pos 30 with an asynchronous reset.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd = 2'd0; adder_sum = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 3 * N) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (pos != PW'(30) && w < 3 * N) begin @(negedge clk); w++; end
    chk("abort_busy", N'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_pos", N'(pos), N'(LAST));
    chk("abort_busy0", N'(busy), 0);
    chk("abort_ready", N'(cmd_ready), 1);
    chk("abort_acc", N'(acc), 0);
    @(posedge clk); #1;
    rst = 1'b0; adder_sum = 1'b0;
    read_store(r);
    chk("abort_store", r, '0);

    rnd_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rv = {$urandom, $urandom, $urandom};
      if (k % 3 == 0) rv[N-1] = 1'b1;
      issue(2'($urandom_range(0, 3)), rv);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    rnd_en = 1'b0;
    repeat (N) @(posedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
